// File: rtl/l2tlb_dr_arb.sv
// l2tlb_dr_arb: shares the L2-to-directory TLB channel between two L2 TLB
// slices. Requests are round-robin arbitrated into one registered output
// stage; directory snacks are broadcast to both slices and held until each
// slice has accepted its copy.
// Optional: define L2TLB_DR_ARB_STATS_EN to add saturating per-slice grant
// counters (gnt_cnt_0, gnt_cnt_1).
module l2tlb_dr_arb #(
   parameter int REQ_W   = 64,
   parameter int SNACK_W = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               l2t_0todr_req_valid,
   output logic               l2t_0todr_req_retry,
   input  logic [REQ_W-1:0]   l2t_0todr_req,
   input  logic               l2t_1todr_req_valid,
   output logic               l2t_1todr_req_retry,
   input  logic [REQ_W-1:0]   l2t_1todr_req,
   output logic               l2todr_req_valid,
   input  logic               l2todr_req_retry,
   output logic [REQ_W-1:0]   l2todr_req,
   input  logic               drtol2_snack_valid,
   output logic               drtol2_snack_retry,
   input  logic [SNACK_W-1:0] drtol2_snack,
   output logic               drtol2t_0_snack_valid,
   input  logic               drtol2t_0_snack_retry,
   output logic [SNACK_W-1:0] drtol2t_0_snack,
   output logic               drtol2t_1_snack_valid,
   input  logic               drtol2t_1_snack_retry,
   output logic [SNACK_W-1:0] drtol2t_1_snack
`ifdef L2TLB_DR_ARB_STATS_EN
   ,
   output logic [15:0]        gnt_cnt_0,
   output logic [15:0]        gnt_cnt_1
`endif
);

   localparam int NUM_SL = 2;

   typedef enum logic { REQ_EMPTY = 1'b0, REQ_FULL = 1'b1 } req_st_t;
   typedef enum logic { SN_IDLE = 1'b0, SN_BCAST = 1'b1 } sn_st_t;

   // ---------------- request path ----------------
   logic [NUM_SL-1:0]            rv;
   logic [NUM_SL-1:0][REQ_W-1:0] rq;
   logic [NUM_SL-1:0]            rretry;
   req_st_t                      req_st, req_nxt;
   logic                         rr_last;
   logic                         free, gnt, win;
   logic [REQ_W-1:0]             req_q;

   assign rv = {l2t_1todr_req_valid, l2t_0todr_req_valid};
   assign rq = {l2t_1todr_req, l2t_0todr_req};

   // Grant decision: winner is the lone requester, or the slice that did not
   // win last when both request.
   always_comb begin
      req_nxt = req_st;
      gnt     = 1'b0;
      win     = 1'b0;
      free    = (req_st == REQ_EMPTY) || !l2todr_req_retry;
      if (free && (|rv)) begin
         gnt     = 1'b1;
         win     = (&rv) ? ~rr_last : rv[1];
         req_nxt = REQ_FULL;
      end else if (free) begin
         req_nxt = REQ_EMPTY;
      end
   end

   // Per-slice retry: everyone waits while the stage is stuck; a valid
   // requester that lost arbitration also waits.
   for (genvar i = 0; i < NUM_SL; i++) begin : g_rretry
      assign rretry[i] = !free || (gnt && rv[i] && (win != 1'(i)));
   end

   // Request state, output register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         req_st  <= REQ_EMPTY;
         req_q   <= '0;
         rr_last <= 1'b1;
      end else begin
         req_st <= req_nxt;
         if (gnt) begin
            req_q   <= rq[win];
            rr_last <= win;
         end
      end
   end

   assign l2t_0todr_req_retry = rretry[0];
   assign l2t_1todr_req_retry = rretry[1];
   assign l2todr_req_valid    = (req_st == REQ_FULL);
   assign l2todr_req          = req_q;

   // ---------------- snack path ----------------
   sn_st_t              sn_st, sn_nxt;
   logic [NUM_SL-1:0]   done, done_nxt;
   logic [NUM_SL-1:0]   sv, sretry, sacc;
   logic [SNACK_W-1:0]  snack_q;
   logic                cmpl, sload;

   assign sretry = {drtol2t_1_snack_retry, drtol2t_0_snack_retry};

   // Each slice sees the snack until it has taken it once.
   for (genvar i = 0; i < NUM_SL; i++) begin : g_slane
      assign sv[i]   = (sn_st == SN_BCAST) && !done[i];
      assign sacc[i] = sv[i] && !sretry[i];
   end

   // Broadcast completes when every slice is done or accepting now; a new
   // snack may be loaded in that same cycle.
   always_comb begin
      sn_nxt   = sn_st;
      done_nxt = done;
      cmpl     = (sn_st == SN_BCAST) && (&(done | sacc));
      sload    = ((sn_st == SN_IDLE) || cmpl) && drtol2_snack_valid;
      if (sload) begin
         sn_nxt   = SN_BCAST;
         done_nxt = '0;
      end else if (cmpl) begin
         sn_nxt   = SN_IDLE;
         done_nxt = '0;
      end else if (sn_st == SN_BCAST) begin
         done_nxt = done | sacc;
      end
   end

   // Snack state, done tracking and payload register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sn_st   <= SN_IDLE;
         done    <= '0;
         snack_q <= '0;
      end else begin
         sn_st <= sn_nxt;
         done  <= done_nxt;
         if (sload) snack_q <= drtol2_snack;
      end
   end

   assign drtol2_snack_retry    = (sn_st == SN_BCAST) && !cmpl;
   assign drtol2t_0_snack_valid = sv[0];
   assign drtol2t_1_snack_valid = sv[1];
   assign drtol2t_0_snack       = snack_q;
   assign drtol2t_1_snack       = snack_q;

`ifdef L2TLB_DR_ARB_STATS_EN
   logic [NUM_SL-1:0][15:0] gcnt;

   // Saturating grant counters, one per slice.
   always_ff @(posedge clk) begin
      if (!reset) begin
         gcnt <= '0;
      end else if (gnt && (gcnt[win] != 16'hFFFF)) begin
         gcnt[win] <= gcnt[win] + 16'd1;
      end
   end

   assign gnt_cnt_0 = gcnt[0];
   assign gnt_cnt_1 = gcnt[1];
`endif

endmodule

// File: tb/tb_l2tlb_dr_arb.sv
// Directed self-checking bench for l2tlb_dr_arb. Inputs change 1 time unit
// after the rising edge; outputs are checked 1 unit later, mid-cycle.
module tb_l2tlb_dr_arb;

   localparam int REQ_W   = 64;
   localparam int SNACK_W = 64;

   logic               clk = 1'b0;
   logic               reset;
   logic               v0, v1, r0, r1, ov, oretry;
   logic [REQ_W-1:0]   q0, q1, oq;
   logic               sv_in, sretry_out;
   logic [SNACK_W-1:0] s_in;
   logic               s0v, s0r, s1v, s1r;
   logic [SNACK_W-1:0] s0, s1;
`ifdef L2TLB_DR_ARB_STATS_EN
   logic [15:0]        gc0, gc1;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   l2tlb_dr_arb #(.REQ_W(REQ_W), .SNACK_W(SNACK_W)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .l2t_0todr_req_valid   (v0),
      .l2t_0todr_req_retry   (r0),
      .l2t_0todr_req         (q0),
      .l2t_1todr_req_valid   (v1),
      .l2t_1todr_req_retry   (r1),
      .l2t_1todr_req         (q1),
      .l2todr_req_valid      (ov),
      .l2todr_req_retry      (oretry),
      .l2todr_req            (oq),
      .drtol2_snack_valid    (sv_in),
      .drtol2_snack_retry    (sretry_out),
      .drtol2_snack          (s_in),
      .drtol2t_0_snack_valid (s0v),
      .drtol2t_0_snack_retry (s0r),
      .drtol2t_0_snack       (s0),
      .drtol2t_1_snack_valid (s1v),
      .drtol2t_1_snack_retry (s1r),
      .drtol2t_1_snack       (s1)
`ifdef L2TLB_DR_ARB_STATS_EN
      ,
      .gnt_cnt_0             (gc0),
      .gnt_cnt_1             (gc1)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one cycle, leave inputs 1 unit after the edge, settle 1 more
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      v0 = 0; v1 = 0; q0 = '0; q1 = '0; oretry = 0;
      sv_in = 0; s_in = '0; s0r = 0; s1r = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      tick();
      tick();
      // reset state
      settle();
      chk("rst_ov", ov, 0);
      chk("rst_oq", oq, 0);
      chk("rst_s0v", s0v, 0);
      chk("rst_s1v", s1v, 0);
      chk("rst_s0", s0, 0);
      chk("rst_r0", r0, 0);
      chk("rst_r1", r1, 0);
      chk("rst_sretry", sretry_out, 0);
      reset = 1'b1;
      tick();

      // single request
      v0 = 1; q0 = 64'h11;
      settle();
      chk("single_r0_c0", r0, 0);
      chk("single_ov_c0", ov, 0);
      tick();
      v0 = 0; q0 = '0;
      settle();
      chk("single_ov_c1", ov, 1);
      chk("single_oq_c1", oq, 64'h11);
      tick();
      settle();
      chk("single_ov_c2", ov, 0);

      // contention from reset: slice 0 first, then alternate
      do_reset();
      v0 = 1; q0 = 64'hA0; v1 = 1; q1 = 64'hB1;
      settle();
      chk("cont_r0_c0", r0, 0);
      chk("cont_r1_c0", r1, 1);
      for (int c = 0; c < 4; c++) begin
         tick();
         settle();
         chk("cont_ov", ov, 1);
         chk("cont_oq", oq, (c % 2 == 0) ? 64'hA0 : 64'hB1);
         chk("cont_r0", r0, (c % 2 == 0) ? 1 : 0);
         chk("cont_r1", r1, (c % 2 == 0) ? 0 : 1);
      end

      // back-pressure while holding 0x33
      do_reset();
      v0 = 1; q0 = 64'h33;
      tick();
      v0 = 1; q0 = 64'h55; v1 = 1; q1 = 64'h44; oretry = 1;
      for (int c = 0; c < 5; c++) begin
         settle();
         chk("bp_ov", ov, 1);
         chk("bp_oq", oq, 64'h33);
         chk("bp_r0", r0, 1);
         chk("bp_r1", r1, 1);
         tick();
      end
      oretry = 0;
      settle();
      chk("bp_rel_r1", r1, 0);
      chk("bp_rel_r0", r0, 1);
      tick();
      v1 = 0; v0 = 0;
      settle();
      chk("bp_rel_ov", ov, 1);
      chk("bp_rel_oq", oq, 64'h44);

      // snack skew
      do_reset();
      sv_in = 1; s_in = 64'h5A; s0r = 0; s1r = 1;
      settle();
      chk("sk_sretry_c0", sretry_out, 0);
      tick();
      s_in = 64'h5B;
      settle();
      chk("sk_s0v_c1", s0v, 1);
      chk("sk_s1v_c1", s1v, 1);
      chk("sk_s0_c1", s0, 64'h5A);
      chk("sk_s1_c1", s1, 64'h5A);
      chk("sk_sretry_c1", sretry_out, 1);
      for (int c = 2; c <= 3; c++) begin
         tick();
         settle();
         chk("sk_s0v_mid", s0v, 0);
         chk("sk_s1v_mid", s1v, 1);
         chk("sk_sretry_mid", sretry_out, 1);
      end
      tick();
      s1r = 0;
      settle();
      chk("sk_s1v_c4", s1v, 1);
      chk("sk_sretry_c4", sretry_out, 0);
      tick();
      sv_in = 0; s_in = '0;
      settle();
      chk("sk_5b_s0v", s0v, 1);
      chk("sk_5b_s1v", s1v, 1);
      chk("sk_5b_pay", s1, 64'h5B);
      chk("sk_5b_sretry", sretry_out, 0);
      tick();
      settle();
      chk("sk_idle_s0v", s0v, 0);
      chk("sk_idle_s1v", s1v, 0);

      // reset mid-operation (FULL and BCAST)
      do_reset();
      v1 = 1; q1 = 64'h77; sv_in = 1; s_in = 64'h99;
      tick();
      v1 = 0; sv_in = 0; oretry = 1; s0r = 1; s1r = 1;
      settle();
      chk("mr_pre_ov", ov, 1);
      chk("mr_pre_s0v", s0v, 1);
      reset = 1'b0;
      tick();
      settle();
      chk("mr_ov", ov, 0);
      chk("mr_s0v", s0v, 0);
      chk("mr_s1v", s1v, 0);
      chk("mr_oq", oq, 0);
      reset = 1'b1;
      oretry = 0; s0r = 0; s1r = 0;
      v0 = 1; q0 = 64'hC0; v1 = 1; q1 = 64'hC1;
      settle();
      chk("mr_first_r0", r0, 0);
      chk("mr_first_r1", r1, 1);
      tick();
      v0 = 0; v1 = 0;
      settle();
      chk("mr_first_oq", oq, 64'hC0);

`ifdef L2TLB_DR_ARB_STATS_EN
      do_reset();
      settle();
      chk("st_rst1", gc1, 0);
      v1 = 1; q1 = 64'h1;
      for (int c = 0; c < 70000; c++) tick();
      v1 = 0;
      tick();
      settle();
      chk("st_sat1", gc1, 16'hFFFF);
      chk("st_cnt0", gc0, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/l2tlb_dr_arb.md
Name: l2tlb_dr_arb

Overview:
- Sequences and shares the single L2-to-directory TLB channel between the two L2 TLB slices (l2t_0, l2t_1) of one core.
- Request path: round-robin arbitration of the two slices' requests into one registered output stage.
- Snack path: one directory snack is broadcast to both slices, and the block tracks per-slice acceptance until both slices have taken it.
- Sits between the per-core L2 TLB slices and the directory aggregator.

Parameters:
- REQ_W, 64, request payload width (bits)
- SNACK_W, 64, snack payload width (bits)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- l2t_0todr_req_valid  in  1  slice 0 request valid
- l2t_0todr_req_retry  out  1  slice 0 request retry
- l2t_0todr_req  in  REQ_W  slice 0 request payload
- l2t_1todr_req_valid  in  1  slice 1 request valid
- l2t_1todr_req_retry  out  1  slice 1 request retry
- l2t_1todr_req  in  REQ_W  slice 1 request payload
- l2todr_req_valid  out  1  arbitrated request valid
- l2todr_req_retry  in  1  directory back-pressure
- l2todr_req  out  REQ_W  arbitrated request payload
- drtol2_snack_valid  in  1  directory snack valid
- drtol2_snack_retry  out  1  snack back-pressure to directory
- drtol2_snack  in  SNACK_W  snack payload
- drtol2t_0_snack_valid  out  1  snack to slice 0, valid
- drtol2t_0_snack_retry  in  1  slice 0 snack retry
- drtol2t_0_snack  out  SNACK_W  snack to slice 0, payload
- drtol2t_1_snack_valid  out  1  snack to slice 1, valid
- drtol2t_1_snack_retry  in  1  slice 1 snack retry
- drtol2t_1_snack  out  SNACK_W  snack to slice 1, payload

Behaviour:
- Handshake on every channel: a transfer happens in a cycle with valid=1 and retry=0. The producer holds valid and payload stable until the transfer. Retry may be asserted whether or not valid is asserted.
- Reset (reset=0 at a clk edge):
  - all valid outputs 0
  - l2todr_req and the snack payloads 0
  - rr_last=1, so slice 0 has priority first
  - snack done bits 0
  - retry outputs follow their combinational equations from the cleared state (both req retries 0; drtol2_snack_retry 0)
  - reset mid-transfer drops any held request or snack; upstream must re-issue.
- Request state, output register: EMPTY/FULL, where FULL is l2todr_req_valid=1.
  - free = EMPTY or (FULL and l2todr_req_retry=0).
- Request grant, when free:
  - one valid requester: that requester wins.
  - both valid: the slice other than rr_last wins.
  - the winner's retry is 0; the loser's retry is 1.
  - on the edge the winner's payload loads into l2todr_req, l2todr_req_valid=1, rr_last=winner.
- When not free: both req retries are 1; the register holds; payload stays stable.
- Latency: input accept to l2todr_req_valid is 1 cycle. Back-to-back accepts sustain 1 request per cycle when the directory does not retry.
- Drain with no new winner: FULL goes to EMPTY.
- rr_last changes only on a grant.
- Snack state: IDLE/BCAST plus done[1:0].
  - BCAST: drtol2t_i_snack_valid = ~done[i]; both slices see the same registered payload.
  - Slice i accepts (valid and retry=0) -> done[i]=1.
  - BCAST completes in the cycle when every slice not already done accepts.
- drtol2_snack_retry = BCAST and not completing this cycle.
- IDLE, or BCAST completing, with drtol2_snack_valid=1: load the payload and enter BCAST with done=00 on the next cycle.
  - A new snack can overlap completion: zero-bubble throughput, 1 snack per cycle when neither slice retries.
- BCAST completing with no incoming snack: go to IDLE, all snack valids 0.
- The request and snack paths are independent and may transfer in the same cycle.

Optional Feature:
- Macro L2TLB_DR_ARB_STATS_EN.
- Defined: adds output ports gnt_cnt_0 and gnt_cnt_1 (16 bits each), 16-bit saturating counts of requests granted per slice.
  - Reset to 0.
  - Increment on each grant.
  - Hold at 0xFFFF once reached.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single request: slice 0 presents req=0x11, directory retry=0 -> slice 0 retry=0 in cycle 0; l2todr_req_valid=1 with l2todr_req=0x11 in cycle 1; valid=0 in cycle 2.
- Contention: both slices valid continuously with 0xA0 (slice 0) and 0xB1 (slice 1), directory never retries -> output sequence 0xA0, 0xB1, 0xA0, 0xB1 on consecutive cycles; the loser's retry=1 each cycle.
- Back-pressure: l2todr_req_retry=1 for 5 cycles while FULL holding 0x33 -> payload stays 0x33, both input retries=1; retry drop -> transfer that cycle and a new grant the same cycle.
- Snack skew: snack 0x5A arrives, slice 0 retry=0, slice 1 retry=1 for 3 cycles -> slice 0 sees valid for 1 cycle only; slice 1 valid 4 cycles; drtol2_snack_retry=1 until the cycle slice 1 accepts; a second snack 0x5B waiting upstream is loaded on that same cycle.
- Reset mid-operation: reset=0 while FULL and BCAST -> next cycle all valids 0, done=00; the first request after reset goes to slice 0 when both request.
- (STATS_EN) 70000 grants to slice 1 -> gnt_cnt_1=0xFFFF, gnt_cnt_0 unchanged.
